// File: rtl/spi_ad7324_if.sv
// Bus bundle between an AD7324-style SPI master and the responder.
//   cs, din, ch_data       : master -> responder (chip select, command bit, 4x13-bit channel words)
//   dout                   : responder -> master serial result bit (combinational on cs)
//   cur_ch, range_val,
//   seq_en, seq_mode       : responder register state
//   frame_done             : one-cycle pulse after each completed 16-bit frame
interface spi_ad7324_if;
    localparam int unsigned CH_W  = 13;
    localparam int unsigned N_CH  = 4;
    localparam int unsigned CHD_W = CH_W * N_CH;

    logic               cs;
    logic               din;
    logic [CHD_W-1:0]   ch_data;
    logic               dout;
    logic [1:0]         cur_ch;
    logic [7:0]         range_val;
    logic [3:0]         seq_en;
    logic [1:0]         seq_mode;
    logic               frame_done;

    modport master (
        output cs, din, ch_data,
        input  dout, cur_ch, range_val, seq_en, seq_mode, frame_done
    );

    modport slave (
        input  cs, din, ch_data,
        output dout, cur_ch, range_val, seq_en, seq_mode, frame_done
    );
endinterface

// File: rtl/spi_ad7324_resp.sv
// AD7324 SPI responder: receives 16-bit command frames on din, decodes control,
// range and sequence register writes, and streams {0, cur_ch, ch_data[cur_ch]}
// back on dout, MSB first.
// Ports:
//   clk_in_i : system clock (same as SCLK), rising edge
//   r_ni     : asynchronous active-low reset
//   bus      : spi_ad7324_if.slave (cs, din, ch_data in; dout, cur_ch,
//              range_val, seq_en, seq_mode, frame_done out)
// dout is combinational so bit 15 is present in the first cs-low cycle.
// Optional feature macro AD7324_RESP_SEQ_EN: automatic channel sequencing on
// each completed non-control frame, driven by seq_mode / seq_en.
module spi_ad7324_resp #(
    parameter logic [1:0] RESET_CH    = 2'd0,
    parameter logic [7:0] RESET_RANGE = 8'h00
) (
    input  logic          clk_in_i,
    input  logic          r_ni,
    spi_ad7324_if.slave   bus
);
    localparam int unsigned FRAME_W = 16;
    localparam int unsigned CH_W    = 13;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [FRAME_W-1:0]     osr_q, osr_d;
    logic [FRAME_W-2:0]     isr_q, isr_d;
    logic [1:0]             cur_ch_q, cur_ch_d;
    logic [7:0]             range_q, range_d;
    logic [3:0]             seq_en_q, seq_en_d;
    logic [1:0]             seq_mode_q, seq_mode_d;
    logic                   frame_done_q, frame_done_d;
`ifdef AD7324_RESP_SEQ_EN
    logic [1:0]             add_q, add_d;
    logic [1:0]             adv_ch_c;
    logic [1:0]             cand;
    logic                   found;
`endif

    logic                   shift_c;
    logic                   last_c;
    logic [FRAME_W-1:0]     word_c;
    logic [CH_W-1:0]        ch_sel_c;
    logic                   ctrl_wr_c;

    // A shift edge is any cs-low edge in IDLE or SHIFT; the IDLE edge carries bit 15.
    assign shift_c   = !bus.cs && (state_q == ST_IDLE || state_q == ST_SHIFT);
    assign last_c    = shift_c && (cnt_q == CNT_W'(FRAME_W - 1));
    assign word_c    = {isr_q, bus.din};
    assign ctrl_wr_c = word_c[15] && (word_c[14:13] == 2'b01);

    // Channel word for the currently selected channel.
    always_comb begin
        ch_sel_c = bus.ch_data[CH_W-1:0];
        case (cur_ch_q)
            2'd0:    ch_sel_c = bus.ch_data[0*CH_W +: CH_W];
            2'd1:    ch_sel_c = bus.ch_data[1*CH_W +: CH_W];
            2'd2:    ch_sel_c = bus.ch_data[2*CH_W +: CH_W];
            default: ch_sel_c = bus.ch_data[3*CH_W +: CH_W];
        endcase
    end

`ifdef AD7324_RESP_SEQ_EN
    // Next channel from the sequencer, using register values held before commit.
    always_comb begin
        adv_ch_c = cur_ch_q;
        cand     = cur_ch_q;
        found    = 1'b0;
        case (seq_mode_q)
            2'b10: begin
                // Scan upward from cur_ch+1, wrapping; a full lap lands back on cur_ch.
                for (int i = 1; i <= 4; i++) begin
                    cand = cur_ch_q + 2'(i);
                    if (!found && seq_en_q[cand]) begin
                        adv_ch_c = cand;
                        found    = 1'b1;
                    end
                end
            end
            2'b11:   adv_ch_c = (cur_ch_q == add_q) ? 2'd0 : cur_ch_q + 2'd1;
            default: adv_ch_c = cur_ch_q;
        endcase
    end
`endif

    // State register.
    always_ff @(posedge clk_in_i or negedge r_ni) begin
        if (!r_ni) begin
            state_q <= ST_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!bus.cs) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bus.cs)      state_d = ST_IDLE;
                else if (last_c) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.cs) state_d = ST_IDLE;
            end
            default: state_d = ST_WAIT;
        endcase
    end

    // Datapath and register next values.
    always_comb begin
        cnt_d        = cnt_q;
        osr_d        = osr_q;
        isr_d        = isr_q;
        cur_ch_d     = cur_ch_q;
        range_d      = range_q;
        seq_en_d     = seq_en_q;
        seq_mode_d   = seq_mode_q;
        frame_done_d = 1'b0;
`ifdef AD7324_RESP_SEQ_EN
        add_d        = add_q;
`endif
        if (bus.cs) begin
            // Snapshot the result word on every cs-high cycle; the last one wins.
            osr_d = {1'b0, cur_ch_q, ch_sel_c};
            cnt_d = '0;
        end else if (shift_c) begin
            osr_d = {osr_q[FRAME_W-2:0], 1'b0};
            isr_d = word_c[FRAME_W-2:0];
            cnt_d = cnt_q + CNT_W'(1);
            if (last_c) begin
                frame_done_d = 1'b1;
`ifdef AD7324_RESP_SEQ_EN
                if (!ctrl_wr_c) cur_ch_d = adv_ch_c;
`endif
                if (word_c[15]) begin
                    case (word_c[14:13])
                        2'b01: begin
                            cur_ch_d   = word_c[11:10];
                            seq_mode_d = word_c[4:3];
`ifdef AD7324_RESP_SEQ_EN
                            add_d      = word_c[11:10];
`endif
                        end
                        2'b10:   range_d  = word_c[12:5];
                        2'b11:   seq_en_d = word_c[12:9];
                        default: ;
                    endcase
                end
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_in_i or negedge r_ni) begin
        if (!r_ni) begin
            cnt_q        <= '0;
            osr_q        <= '0;
            isr_q        <= '0;
            cur_ch_q     <= RESET_CH;
            range_q      <= RESET_RANGE;
            seq_en_q     <= '0;
            seq_mode_q   <= '0;
            frame_done_q <= 1'b0;
`ifdef AD7324_RESP_SEQ_EN
            add_q        <= '0;
`endif
        end else begin
            cnt_q        <= cnt_d;
            osr_q        <= osr_d;
            isr_q        <= isr_d;
            cur_ch_q     <= cur_ch_d;
            range_q      <= range_d;
            seq_en_q     <= seq_en_d;
            seq_mode_q   <= seq_mode_d;
            frame_done_q <= frame_done_d;
`ifdef AD7324_RESP_SEQ_EN
            add_q        <= add_d;
`endif
        end
    end

    assign bus.dout       = shift_c && osr_q[FRAME_W-1];
    assign bus.cur_ch     = cur_ch_q;
    assign bus.range_val  = range_q;
    assign bus.seq_en     = seq_en_q;
    assign bus.seq_mode   = seq_mode_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_spi_ad7324_resp.sv
// Scoreboard bench for spi_ad7324_resp: the driver pushes the expected result
// word and post-frame register state for every complete frame; a negedge
// monitor assembles dout and checks each entry when frame_done pulses.
module tb_spi_ad7324_resp;
    logic clk = 1'b0;
    logic r_n;
    always #5 clk = ~clk;

    spi_ad7324_if bus();

    spi_ad7324_resp dut (
        .clk_in_i (clk),
        .r_ni     (r_n),
        .bus      (bus)
    );

    typedef struct {
        logic [15:0] word;
        logic [1:0]  ch;
        logic [7:0]  rng;
        logic [3:0]  en;
        logic [1:0]  mode;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          done_seen = 0;
    int          done_exp = 0;
    logic        quiet = 1'b0;

    // Reference model state
    logic [12:0] chd [4];
    logic [1:0]  m_ch;
    logic [7:0]  m_rng;
    logic [3:0]  m_en;
    logic [1:0]  m_mode;
    logic [1:0]  m_add;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_chd();
        for (int c = 0; c < 4; c++) bus.ch_data[c*13 +: 13] = chd[c];
    endtask

    task automatic rand_chd();
        for (int c = 0; c < 4; c++) chd[c] = 13'($urandom);
        drive_chd();
    endtask

    task automatic model_reset();
        m_ch = 2'd0; m_rng = 8'h00; m_en = 4'h0; m_mode = 2'd0; m_add = 2'd0;
    endtask

    // Applies the effect of one completed frame carrying command w.
    task automatic model_commit(input logic [15:0] w);
        logic [1:0] old_mode;
        logic [3:0] old_en;
        int         en_list[$];
        bit         ctrl;
        old_mode = m_mode;
        old_en   = m_en;
        ctrl     = w[15] && (w[14:13] == 2'b01);
`ifdef AD7324_RESP_SEQ_EN
        if (!ctrl) begin
            if (old_mode == 2'b10) begin
                for (int c = 0; c < 4; c++) if (old_en[c]) en_list.push_back(c);
                if (en_list.size() != 0) begin
                    int nxt;
                    nxt = en_list[0];
                    foreach (en_list[j]) begin
                        if (en_list[j] > int'(m_ch)) begin
                            nxt = en_list[j];
                            break;
                        end
                    end
                    m_ch = 2'(nxt);
                end
            end else if (old_mode == 2'b11) begin
                m_ch = (m_ch == m_add) ? 2'd0 : 2'((int'(m_ch) + 1) % 4);
            end
        end
`else
        if (old_mode == old_mode && old_en == old_en) en_list.delete();
`endif
        if (w[15]) begin
            case (w[14:13])
                2'b01: begin m_ch = w[11:10]; m_mode = w[4:3]; m_add = w[11:10]; end
                2'b10: m_rng = w[12:5];
                2'b11: m_en = w[12:9];
                default: ;
            endcase
        end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, " cur_ch"},   bus.cur_ch,    m_ch);
        chk({tag, " range"},    bus.range_val, m_rng);
        chk({tag, " seq_en"},   bus.seq_en,    m_en);
        chk({tag, " seq_mode"}, bus.seq_mode,  m_mode);
    endtask

    // One frame: a cs-high cycle, nbits command bits, extra cs-low cycles.
    // nbits < 16 aborts the frame. Called and returns at posedge+1.
    task automatic do_frame(input logic [15:0] w, input int nbits, input int extra, input bit rnd);
        exp_t e;
        bus.cs  = 1'b1;
        bus.din = 1'b0;
        if (rnd) rand_chd(); else drive_chd();
        @(posedge clk); #1;
        e.word = {1'b0, m_ch, chd[m_ch]};
        if (nbits == 16) begin
            model_commit(w);
            e.ch = m_ch; e.rng = m_rng; e.en = m_en; e.mode = m_mode;
            sb.push_back(e);
            done_exp++;
        end
        bus.cs = 1'b0;
        for (int k = 0; k < nbits; k++) begin
            bus.din = w[15-k];
            if (k > 0 && ($urandom % 2) == 0) rand_chd();
            @(posedge clk); #1;
        end
        for (int k = 0; k < extra; k++) begin
            bus.din = 1'($urandom);
            @(posedge clk); #1;
        end
        bus.cs  = 1'b1;
        bus.din = 1'b0;
        if (nbits < 16) chk_regs("abort");
    endtask

    // Monitor: assemble dout during each frame, score on frame_done.
    int          bits = 0;
    logic [15:0] got = '0;
    always @(negedge clk) begin
        if (bus.frame_done === 1'b1) begin
            done_seen++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected frame_done: got 1 expected 0 at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("frame_done cycle", 32'(bits), 32'd16);
                chk("dout word", got, e.word);
                chk("cur_ch", bus.cur_ch, e.ch);
                chk("range", bus.range_val, e.rng);
                chk("seq_en", bus.seq_en, e.en);
                chk("seq_mode", bus.seq_mode, e.mode);
            end
        end
        if (bus.cs) begin
            bits = 0;
        end else if (quiet || bits >= 16) begin
            bits = 16;
            chk("dout quiet", bus.dout, 1'b0);
        end else begin
            got  = {got[14:0], bus.dout};
            bits = bits + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        r_n = 1'b0;
        bus.cs = 1'b1;
        bus.din = 1'b0;
        for (int c = 0; c < 4; c++) chd[c] = '0;
        drive_chd();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset dout", bus.dout, 1'b0);
        chk("reset frame_done", bus.frame_done, 1'b0);
        chk_regs("reset");
        r_n = 1'b1;
        @(posedge clk); #1;

        // Plain read of channel 0
        chd[0] = 13'h0ABC;
        do_frame(16'h0000, 16, 0, 1'b0);
        // Control write ADD=2, then read ch2
        do_frame(16'hA800, 16, 0, 1'b1);
        chd[2] = 13'h1FFF;
        do_frame(16'h0000, 16, 0, 1'b0);
        // Range write, then aborted range write
        do_frame(16'hDFE0, 16, 0, 1'b1);
        do_frame(16'hC000, 8, 0, 1'b1);
        // Sequencer: SEQ_EN=1010, control ADD=1 mode 10, then reads
        do_frame(16'hF400, 16, 0, 1'b1);
        do_frame(16'hA410, 16, 0, 1'b1);
        repeat (4) do_frame(16'h0000, 16, 0, 1'b1);
        // CS held past 16 bits
        do_frame(16'h8000, 16, 5, 1'b1);

        // Reset mid-frame at bit 7 with cs held low
        bus.cs = 1'b1;
        rand_chd();
        @(posedge clk); #1;
        bus.cs = 1'b0;
        for (int k = 0; k < 7; k++) begin
            bus.din = 1'b1;
            @(posedge clk); #1;
        end
        quiet = 1'b1;
        r_n = 1'b0;
        model_reset();
        #1;
        chk("reset mid-frame dout", bus.dout, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        r_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.din = 1'($urandom);
            @(posedge clk); #1;
        end
        chk_regs("post reset");
        bus.cs = 1'b1;
        @(posedge clk); #1;
        quiet = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            w = 16'($urandom);
            if (sel < 3)      w[15:13] = 3'b101;
            else if (sel < 5) w[15:13] = 3'b110;
            else if (sel < 7) w[15:13] = 3'b111;
            if (($urandom % 8) == 0)
                do_frame(w, int'($urandom_range(1, 15)), 0, 1'b1);
            else
                do_frame(w, 16, (($urandom % 6) == 0) ? int'($urandom_range(1, 4)) : 0, 1'b1);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        chk("frame_done count", 32'(done_seen), 32'(done_exp));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
